// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding plus ID-stage load-use / multiply hazard detection.
// Tracks one in-flight multiply and keeps a saturating count of stalled cycles.
module hazard_forward_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_is_mul,
  input  logic [REG_ADDR_W-1:0] ex_reg_rs,
  input  logic [REG_ADDR_W-1:0] ex_reg_rt,
  input  logic [REG_ADDR_W-1:0] ex_reg_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_mul_start,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_reg_rd,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_reg_rd,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall,
  output logic                  flush_ex,
  output logic                  mul_busy,
  output logic                  mul_done,
  output logic [REG_ADDR_W-1:0] mul_rd,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int               CW       = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CW-1:0]    CNT_INIT = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CNT_W-1:0] SC_ONE   = CNT_W'(1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] mul_rd_q, mul_rd_d;
  logic [CNT_W-1:0]      stall_count_q, stall_count_d;

  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       ex_rd_read, mul_rd_read;
  logic       stall_raw, busy_raw, done_raw;

  // True when the ID instruction actually reads register r; $0 never counts.
  function automatic logic src_match(
    input logic [REG_ADDR_W-1:0] r,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  use_rs,
    input logic                  use_rt
  );
    return (r != '0) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
  endfunction

  // MEM is the younger producer, so it has priority over WB.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  m_wr,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  w_wr,
    input logic [REG_ADDR_W-1:0] w_rd
  );
    if (m_wr && (m_rd != '0) && (m_rd == src)) begin
      return 2'b10;
    end
    if (w_wr && (w_rd != '0) && (w_rd == src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a_raw   = fwd_sel(ex_reg_rs, mem_reg_write, mem_reg_rd, wb_reg_write, wb_reg_rd);
    fwd_b_raw   = fwd_sel(ex_reg_rt, mem_reg_write, mem_reg_rd, wb_reg_write, wb_reg_rd);
    ex_rd_read  = src_match(ex_reg_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);
    mul_rd_read = src_match(mul_rd_q,  id_rs, id_rt, id_uses_rs, id_uses_rt);
  end

  // State register and multiply bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mul_rd_q      <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mul_rd_q      <= mul_rd_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Next-state logic; a start seen while BUSY is dropped.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mul_rd_d = mul_rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ex_mul_start) begin
          state_d  = ST_BUSY;
          cnt_d    = CNT_INIT;
          mul_rd_d = ex_reg_rd;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ex_mul_start) begin
          state_d  = ST_BUSY;
          cnt_d    = CNT_INIT;
          mul_rd_d = ex_reg_rd;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic; everything except the latched registers is held low during reset.
  always_comb begin
    busy_raw  = (state_q != ST_IDLE);
    done_raw  = (state_q == ST_DONE);
    stall_raw = (ex_mem_read  && ex_rd_read)
             || (ex_mul_start && ex_rd_read)
             || (busy_raw     && mul_rd_read)
             || ((state_q == ST_BUSY) && id_is_mul);

    forward_a = reset ? 2'b00 : fwd_a_raw;
    forward_b = reset ? 2'b00 : fwd_b_raw;
    stall     = stall_raw && !reset;
    flush_ex  = stall_raw && !reset;
    mul_busy  = busy_raw  && !reset;
    mul_done  = done_raw  && !reset;
    mul_rd    = mul_rd_q;

    stall_count_d = stall_count_q;
    if (stall_raw && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + SC_ONE;
    end
  end

  assign stall_count = stall_count_q;

endmodule
